load_memory_unit: RTL
=====================

Name: load_memory_unit

Overview:
- Back end of the load path, directly downstream of the execution stage's address generator.
- Accepts resolved loads (address, funct3, rob_id, rd_phy) from the execution bus and buffers them in an in-order FIFO.
- Performs one data-memory read at a time using a req/ack handshake, then extracts and extends the addressed byte, half or word.
- Writes the result back to the PRF/ROB with its rob_id and rd_phy. Drives busy_lsu back toward issue.

Parameters:
- ADDR_WIDTH, 32, address width.
- DATA_WIDTH, 32, data width (byte-lane logic fixed for 32).
- ROB_WIDTH, 5, ROB index width.
- PHY_WIDTH, 6, physical register index width.
- DEPTH, 4, load FIFO entries (power of 2, ≥2).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-low reset
- flush  in  1  pipeline flush (mispredict)
- load_valid  in  1  load from execution stage
- load_raddr  in  ADDR_WIDTH  byte address
- load_funct3  in  3  LB=0 LH=1 LW=2 LBU=4 LHU=5
- load_rob_id  in  ROB_WIDTH  ROB tag
- load_rd_phy  in  PHY_WIDTH  destination physical register
- busy_lsu  out  1  FIFO full; issue must not send a load
- mem_req  out  1  read request
- mem_addr  out  ADDR_WIDTH  word-aligned address {raddr[31:2],2'b00}
- mem_ack  in  1  memory returns mem_rdata this cycle
- mem_rdata  in  DATA_WIDTH  read word
- wb_valid  out  1  writeback strobe (one cycle)
- wb_data  out  DATA_WIDTH  extended load result
- wb_rob_id  out  ROB_WIDTH  tag of completing load
- wb_rd_phy  out  PHY_WIDTH  destination register
- wb_exception  out  1  misaligned or illegal funct3; wb_data=0

Behaviour:
- Reset (rst=0 at an edge):
  - Pointers, count and FSM go to 0/IDLE.
  - All outputs are 0 from that edge on: mem_req, wb_valid, wb_exception, busy_lsu, wb_data, wb_rob_id, wb_rd_phy, mem_addr.
  - A reset mid-transaction abandons it; the memory side must tolerate a dropped request.
- Enqueue:
  - At an edge with load_valid=1 and count<DEPTH, the entry is written at the tail.
  - load_valid while full is ignored. Upstream must respect busy_lsu.
- busy_lsu = (count==DEPTH), combinational from registered count. It does not account for a same-cycle pop.
- FSM (state registered; outputs decoded from state + head entry):
  - IDLE:
    - FIFO non-empty and head legal -> REQ.
    - Head misaligned or illegal -> RESP with exc flag set.
  - REQ:
    - mem_req=1; mem_addr held stable from the head entry.
    - mem_ack=1 at an edge -> capture mem_rdata into a data register; -> RESP.
    - mem_ack=0 -> stay in REQ.
  - RESP:
    - wb_valid=1 for exactly one cycle; head pops at the next edge; -> IDLE.
    - wb_rob_id and wb_rd_phy come from the head entry.
  - DRAIN:
    - mem_req=1 until mem_ack; data discarded; -> IDLE. No writeback.
- Minimum latency: load_valid at edge t -> REQ after t+1 -> with mem_ack=1 at t+2, wb_valid high between t+2 and t+3. Three cycles.
- Loads complete strictly in FIFO order. One outstanding memory request at most.
- Extraction, with off = raddr[1:0]:
  - LB/LBU: byte at rdata[8*off+:8], sign- or zero-extended.
  - LH/LHU: half at rdata[16*off[1]+:16], sign- or zero-extended.
  - LW: full word.
- Misaligned: LH/LHU with raddr[0]=1, or LW with raddr[1:0]≠0. No memory request; wb_valid=1, wb_exception=1, wb_data=0.
- Illegal funct3 (3, 6, 7): handled the same as misaligned.
- Flush (synchronous, at edge):
  - FIFO emptied, count=0.
  - REQ -> DRAIN.
  - RESP -> IDLE; wb_valid is gated combinationally by !flush, so no writeback in the flush cycle.
  - IDLE -> IDLE.
  - Flush and load_valid in the same cycle: flush wins, nothing enqueued.
- Pointers are log2(DEPTH) bits and wrap modulo DEPTH. count is log2(DEPTH)+1 bits.
- Push and pop at the same edge: count unchanged.

Test Plan:
- Single LW at 0x100, mem_ack one cycle after mem_req, rdata=0xDEADBEEF -> mem_addr=0x100; wb_valid once with wb_data=0xDEADBEEF, correct rob_id/rd_phy; three-cycle latency.
- LB at 0x103 and LBU at 0x103, rdata=0x80FF_1234 -> wb_data=0xFFFFFF80, then 0x00000080. LH at 0x102 -> 0xFFFF80FF.
- Six back-to-back loads with mem_ack held low for 10 cycles -> busy_lsu=1 once count=4; loads 5–6 are held off and sent only after busy drops; writebacks appear in issue order with matching rob_ids.
- LW at 0x101 -> no mem_req; wb_valid=1, wb_exception=1, wb_data=0. The next queued legal load then completes normally.
- Flush while in REQ with 3 queued loads, mem_ack 4 cycles later -> mem_req stays high until ack, no wb_valid, FIFO empty, busy_lsu=0. A new load after the drain completes correctly.
- rst=0 asserted while in REQ with 2 queued loads -> next cycle mem_req=0, wb_valid=0, count=0. Flush coincident with load_valid -> load not enqueued.

Source files
------------

// File: rtl/load_memory_unit.sv
// rtl/load_memory_unit.sv - in-order load FIFO, single-outstanding data-memory read, byte/half/word extraction and writeback
//
// Purpose:
//   Buffers resolved loads from the execution stage, performs one memory read
//   at a time over a req/ack handshake, extends the addressed byte/half/word
//   and writes the result back with its ROB tag and destination register.
//
// Ports:
//   clk, rst           clock, synchronous active-low reset
//   flush              pipeline flush: empties the FIFO, drains any open request
//   load_valid/_raddr/_funct3/_rob_id/_rd_phy   incoming resolved load
//   busy_lsu           FIFO full, upstream must hold loads
//   mem_req/mem_addr   word-aligned read request
//   mem_ack/mem_rdata  read completion and data
//   wb_valid/_data/_rob_id/_rd_phy/_exception   one-cycle writeback

module load_memory_unit #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int ROB_WIDTH  = 5,
    parameter int PHY_WIDTH  = 6,
    parameter int DEPTH      = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic                  load_valid,
    input  logic [ADDR_WIDTH-1:0] load_raddr,
    input  logic [2:0]            load_funct3,
    input  logic [ROB_WIDTH-1:0]  load_rob_id,
    input  logic [PHY_WIDTH-1:0]  load_rd_phy,
    output logic                  busy_lsu,
    output logic                  mem_req,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic                  mem_ack,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic                  wb_valid,
    output logic [DATA_WIDTH-1:0] wb_data,
    output logic [ROB_WIDTH-1:0]  wb_rob_id,
    output logic [PHY_WIDTH-1:0]  wb_rd_phy,
    output logic                  wb_exception
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] FULL_COUNT = (PTR_W+1)'(DEPTH);

    localparam logic [2:0] F3_LB  = 3'd0;
    localparam logic [2:0] F3_LH  = 3'd1;
    localparam logic [2:0] F3_LW  = 3'd2;
    localparam logic [2:0] F3_LBU = 3'd4;
    localparam logic [2:0] F3_LHU = 3'd5;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_REQ   = 2'd1,
        S_RESP  = 2'd2,
        S_DRAIN = 2'd3
    } state_t;

    state_t r_state;
    state_t w_state_next;

    // FIFO storage; contents need no reset because count gates every read
    logic [ADDR_WIDTH-1:0] r_q_addr   [DEPTH];
    logic [2:0]            r_q_funct3 [DEPTH];
    logic [ROB_WIDTH-1:0]  r_q_rob    [DEPTH];
    logic [PHY_WIDTH-1:0]  r_q_phy    [DEPTH];

    logic [PTR_W-1:0]      r_head;
    logic [PTR_W-1:0]      r_tail;
    logic [PTR_W:0]        r_count;

    logic                  r_exc;
    logic [DATA_WIDTH-1:0] r_data;
    logic [ADDR_WIDTH-1:0] r_mem_addr;

    logic                  w_full;
    logic                  w_empty;
    logic                  w_push;
    logic                  w_pop;
    logic                  w_start_req;
    logic                  w_start_exc;

    logic [ADDR_WIDTH-1:0] w_head_addr;
    logic [2:0]            w_head_funct3;
    logic [1:0]            w_head_off;
    logic                  w_illegal;
    logic                  w_misaligned;
    logic                  w_bad;

    logic [7:0]            w_byte;
    logic [15:0]           w_half;
    logic [DATA_WIDTH-1:0] w_ext;

    assign w_full  = (r_count == FULL_COUNT);
    assign w_empty = (r_count == '0);
    // Flush wins over a same-cycle load; a full FIFO silently drops the load
    assign w_push  = load_valid && !w_full && !flush;
    assign w_pop   = (r_state == S_RESP) && !flush;

    assign w_head_addr   = r_q_addr[r_head];
    assign w_head_funct3 = r_q_funct3[r_head];
    assign w_head_off    = w_head_addr[1:0];

    always_comb begin
        w_illegal    = 1'b0;
        w_misaligned = 1'b0;
        case (w_head_funct3)
            F3_LB, F3_LBU: w_misaligned = 1'b0;
            F3_LH, F3_LHU: w_misaligned = w_head_off[0];
            F3_LW:         w_misaligned = (w_head_off != 2'b00);
            default:       w_illegal    = 1'b1;
        endcase
    end

    assign w_bad = w_illegal || w_misaligned;

    always_comb begin
        w_state_next = r_state;
        w_start_req  = 1'b0;
        w_start_exc  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (!flush && !w_empty) begin
                    if (w_bad) begin
                        w_state_next = S_RESP;
                        w_start_exc  = 1'b1;
                    end else begin
                        w_state_next = S_REQ;
                        w_start_req  = 1'b1;
                    end
                end
            end
            S_REQ: begin
                // An ack landing with the flush already closes the request,
                // so there is nothing left to drain
                if (mem_ack) begin
                    w_state_next = flush ? S_IDLE : S_RESP;
                end else if (flush) begin
                    w_state_next = S_DRAIN;
                end
            end
            S_RESP: begin
                w_state_next = S_IDLE;
            end
            S_DRAIN: begin
                if (mem_ack) begin
                    w_state_next = S_IDLE;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state    <= S_IDLE;
            r_head     <= '0;
            r_tail     <= '0;
            r_count    <= '0;
            r_exc      <= 1'b0;
            r_data     <= '0;
            r_mem_addr <= '0;
        end else begin
            r_state <= w_state_next;

            if (flush) begin
                r_head  <= '0;
                r_tail  <= '0;
                r_count <= '0;
            end else begin
                if (w_push) begin
                    r_tail <= r_tail + PTR_W'(1);
                end
                if (w_pop) begin
                    r_head <= r_head + PTR_W'(1);
                end
                case ({w_push, w_pop})
                    2'b10:   r_count <= r_count + (PTR_W+1)'(1);
                    2'b01:   r_count <= r_count - (PTR_W+1)'(1);
                    default: r_count <= r_count;
                endcase
            end

            if (w_start_exc) begin
                r_exc <= 1'b1;
            end else if (w_start_req) begin
                r_exc      <= 1'b0;
                // Latched so the address stays put through a drain after flush
                r_mem_addr <= {w_head_addr[ADDR_WIDTH-1:2], 2'b00};
            end

            if ((r_state == S_REQ) && mem_ack) begin
                r_data <= mem_rdata;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_q_addr[r_tail]   <= load_raddr;
            r_q_funct3[r_tail] <= load_funct3;
            r_q_rob[r_tail]    <= load_rob_id;
            r_q_phy[r_tail]    <= load_rd_phy;
        end
    end

    always_comb begin
        w_byte = 8'h00;
        case (w_head_off)
            2'd0:    w_byte = r_data[7:0];
            2'd1:    w_byte = r_data[15:8];
            2'd2:    w_byte = r_data[23:16];
            default: w_byte = r_data[31:24];
        endcase
        w_half = w_head_off[1] ? r_data[31:16] : r_data[15:0];

        w_ext = '0;
        case (w_head_funct3)
            F3_LB:   w_ext = {{(DATA_WIDTH-8){w_byte[7]}}, w_byte};
            F3_LBU:  w_ext = {{(DATA_WIDTH-8){1'b0}}, w_byte};
            F3_LH:   w_ext = {{(DATA_WIDTH-16){w_half[15]}}, w_half};
            F3_LHU:  w_ext = {{(DATA_WIDTH-16){1'b0}}, w_half};
            F3_LW:   w_ext = r_data;
            default: w_ext = '0;
        endcase
    end

    assign busy_lsu     = w_full;
    assign mem_req      = (r_state == S_REQ) || (r_state == S_DRAIN);
    assign mem_addr     = r_mem_addr;
    // The flush gate keeps a squashed load from reaching the PRF/ROB
    assign wb_valid     = (r_state == S_RESP) && !flush;
    assign wb_exception = wb_valid && r_exc;
    assign wb_data      = (wb_valid && !r_exc) ? w_ext : '0;
    assign wb_rob_id    = wb_valid ? r_q_rob[r_head] : '0;
    assign wb_rd_phy    = wb_valid ? r_q_phy[r_head] : '0;

endmodule
